// File: rtl/collatz_dispatch_if.sv
// Bus bundle for collatz_dispatch: job control, iterator fan-out and result RAM write port.
// The master modport is the dispatcher side; the slave modport is the environment side.
interface collatz_dispatch_if #(
  parameter int NUM_UNITS     = 4,
  parameter int RAM_ADDR_BITS = 4
);
  logic                     go;
  logic [31:0]              start;
  logic                     busy;
  logic                     done;
  logic [NUM_UNITS-1:0]     cgo;
  logic [31:0]              cn;
  logic [NUM_UNITS-1:0]     cdone;
  logic                     we;
  logic [RAM_ADDR_BITS-1:0] waddr;
  logic [15:0]              wdata;

  modport master (
    input  go, start, cdone,
    output busy, done, cgo, cn, we, waddr, wdata
  );

  modport slave (
    output go, start, cdone,
    input  busy, done, cgo, cn, we, waddr, wdata
  );
endinterface

// File: rtl/collatz_dispatch.sv
// Shares one RAM-filling job across NUM_UNITS external collatz iterators, timing each run
// in cycles and writing the counts into the result RAM in completion order.
module collatz_dispatch #(
  parameter int NUM_UNITS     = 4,
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  collatz_dispatch_if.master bus
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [RAM_ADDR_BITS-1:0] LAST_OFF = RAM_ADDR_BITS'(RAM_WORDS - 1);
  localparam logic [RAM_ADDR_BITS:0]   LAST_WR  = (RAM_ADDR_BITS + 1)'(RAM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [2:0] {U_FREE, U_ARM, U_CLR, U_RUN, U_HOLD} unit_t;

  state_t                   state;
  unit_t                    ustate [NUM_UNITS];
  logic [15:0]              count  [NUM_UNITS];
  logic [RAM_ADDR_BITS-1:0] tag    [NUM_UNITS];
  logic [31:0]              base;
  logic [RAM_ADDR_BITS-1:0] off;
  logic [RAM_ADDR_BITS:0]   wr_cnt;
  logic [UW-1:0]            last;

  logic          issue_ok;
  logic [UW-1:0] issue_idx;
  logic          grant_ok;
  logic [UW-1:0] grant_idx;
  logic [UW-1:0] cand;

  // Lowest-index free slot takes the next offset.
  always_comb begin
    issue_ok  = 1'b0;
    issue_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (ustate[i] == U_FREE) begin
        issue_ok  = 1'b1;
        issue_idx = UW'(i);
      end
    end
  end

  // Round-robin over held slots, searching from the one after the last granted.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_UNITS; k >= 1; k--) begin
      cand = UW'((int'(last) + k) % NUM_UNITS);
      if (ustate[cand] == U_HOLD) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      for (int i = 0; i < NUM_UNITS; i++) begin
        ustate[i] <= U_FREE;
        count[i]  <= '0;
        tag[i]    <= '0;
      end
      base      <= '0;
      off       <= '0;
      wr_cnt    <= '0;
      last      <= UW'(NUM_UNITS - 1);
      bus.cgo   <= '0;
      bus.cn    <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.cgo <= '0;
      bus.we  <= 1'b0;

      // U_ARM skips one cycle so a stale cdone from the previous run is never counted.
      for (int i = 0; i < NUM_UNITS; i++) begin
        case (ustate[i])
          U_ARM:   ustate[i] <= U_CLR;
          U_CLR:   if (!bus.cdone[i]) ustate[i] <= U_RUN;
          U_RUN: begin
            if (bus.cdone[i])              ustate[i] <= U_HOLD;
            else if (count[i] != 16'hFFFF) count[i]  <= count[i] + 16'd1;
          end
          default: ;
        endcase
      end

      if (grant_ok) begin
        bus.we            <= 1'b1;
        bus.waddr         <= tag[grant_idx];
        bus.wdata         <= count[grant_idx];
        ustate[grant_idx] <= U_FREE;
        last              <= grant_idx;
      end

      if (bus.we) wr_cnt <= wr_cnt + 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.go) begin
            state    <= S_RUN;
            base     <= bus.start;
            off      <= '0;
            wr_cnt   <= '0;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
          end
        end
        S_RUN: begin
          if (issue_ok) begin
            bus.cgo[issue_idx] <= 1'b1;
            bus.cn             <= base + {{(32 - RAM_ADDR_BITS){1'b0}}, off};
            tag[issue_idx]     <= off;
            count[issue_idx]   <= 16'd1;
            ustate[issue_idx]  <= U_ARM;
            off                <= off + 1'b1;
            if (off == LAST_OFF) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.we && wr_cnt == LAST_WR) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_dispatch.sv
// Self-checking bench for collatz_dispatch: behavioural iterators drive cdone, and every
// written count is compared with the Collatz sequence length computed arithmetically.
module tb_collatz_dispatch;

  localparam int NU = 4;
  localparam int RW = 16;
  localparam int AB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic hold  = 1'b0;

  always #5 clk = ~clk;

  collatz_dispatch_if #(.NUM_UNITS(NU), .RAM_ADDR_BITS(AB)) bus ();

  collatz_dispatch #(.NUM_UNITS(NU), .RAM_WORDS(RW), .RAM_ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Iterators load n on cgo and step once per cycle; hold freezes them with cdone forced high.
  logic [31:0]   it_x [NU];
  logic [NU-1:0] it_done = '1;

  always @(posedge clk) begin
    for (int i = 0; i < NU; i++) begin
      if (bus.cgo[i]) begin
        it_x[i]    <= bus.cn;
        it_done[i] <= 1'b0;
      end else if (!hold && !it_done[i]) begin
        if (it_x[i] == 32'd1) it_done[i] <= 1'b1;
        else                  it_x[i]    <= it_x[i][0] ? (3 * it_x[i] + 32'd1) : (it_x[i] >> 1);
      end
    end
  end

  assign bus.cdone = it_done | {NU{hold}};

  int          checks = 0;
  int          errors = 0;
  int          wr_addr [RW];
  int          wr_cyc  [RW];
  int          nw;
  logic [15:0] ram  [RW];
  bit          seen [RW];

  function automatic logic [31:0] clen(input logic [31:0] n);
    int c = 1;
    while (n != 32'd1 && c < 100000) begin
      n = n[0] ? (3 * n + 32'd1) : (n >> 1);
      c++;
    end
    return 32'(c);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] s);
    @(negedge clk);
    bus.go    = 1'b1;
    bus.start = s;
    @(negedge clk);
    bus.go    = 1'b0;
    checkOutput("busy_after_go", 32'(bus.busy), 32'd1);
    checkOutput("done_after_go", 32'(bus.done), 32'd0);
  endtask

  // Watches one job to completion; optionally pulses go with a bogus start while running.
  task automatic collectJob(input logic [31:0] s, input bit glitch);
    int cyc = 0;
    int a;
    bit fin = 0;
    nw = 0;
    for (int i = 0; i < RW; i++) seen[i] = 1'b0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 3) begin
        bus.go    = 1'b1;
        bus.start = 32'd999;
      end else begin
        bus.go = 1'b0;
      end
      if (bus.we === 1'b1) begin
        a = int'(bus.waddr);
        checkOutput("waddr_unique", 32'(seen[a]), 32'd0);
        checkOutput($sformatf("wdata[%0d]", a), 32'(bus.wdata), clen(s + 32'(a)));
        seen[a] = 1'b1;
        ram[a]  = bus.wdata;
        if (nw < RW) begin
          wr_addr[nw] = a;
          wr_cyc[nw]  = cyc;
        end
        nw++;
        if (nw == RW) begin
          checkOutput("done_before_last", 32'(bus.done), 32'd0);
          @(negedge clk);
          checkOutput("done_after_last", 32'(bus.done), 32'd1);
          checkOutput("busy_after_last", 32'(bus.busy), 32'd0);
          checkOutput("we_after_last", 32'(bus.we), 32'd0);
          fin = 1'b1;
        end
      end
    end
    checkOutput("job_finished", 32'(fin), 32'd1);
    checkOutput("write_count", 32'(nw), 32'(RW));
  endtask

  initial begin
    int  n_we;
    int  n_iss;
    bit  ooo;
    logic [31:0] s;

    bus.go    = 1'b0;
    bus.start = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_cgo", 32'(bus.cgo), 32'd0);
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_waddr", 32'(bus.waddr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.wdata), 32'd0);
    checkOutput("rst_cn", bus.cn, 32'd0);
    reset = 1'b0;

    $display("[TB] cdone held high through issue, start=12");
    hold = 1'b1;
    applyStimulus(32'd12);
    n_we  = 0;
    n_iss = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.we === 1'b1) n_we++;
      n_iss += $countones(bus.cgo);
    end
    checkOutput("no_we_while_held", 32'(n_we), 32'd0);
    checkOutput("issued_while_held", 32'(n_iss), 32'(NU));
    hold = 1'b0;
    collectJob(32'd12, 1'b0);
    checkOutput("tie_first_addr", 32'(wr_addr[0]), 32'd0);
    checkOutput("tie_second_addr", 32'(wr_addr[1]), 32'd1);
    checkOutput("tie_consecutive", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
    checkOutput("tie_count", 32'(ram[0]), 32'd10);

    $display("[TB] job start=1");
    applyStimulus(32'd1);
    collectJob(32'd1, 1'b0);
    checkOutput("ram0_start1", 32'(ram[0]), 32'd1);
    checkOutput("ram1_start1", 32'(ram[1]), 32'd2);
    checkOutput("ram2_start1", 32'(ram[2]), 32'd8);

    $display("[TB] job start=27");
    applyStimulus(32'd27);
    collectJob(32'd27, 1'b0);
    checkOutput("ram0_start27", 32'(ram[0]), 32'd112);
    ooo = 1'b0;
    for (int k = 0; k < RW; k++) if (wr_addr[k] != k) ooo = 1'b1;
    checkOutput("out_of_order", 32'(ooo), 32'd1);

    $display("[TB] job start=100 with go pulsed while running");
    applyStimulus(32'd100);
    collectJob(32'd100, 1'b1);

    repeat (3) begin
      s = 32'($urandom_range(1, 5000));
      $display("[TB] random job start=%0d", s);
      applyStimulus(s);
      collectJob(s, 1'b0);
    end

    $display("[TB] reset during run");
    applyStimulus(32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cgo", 32'(bus.cgo), 32'd0);
    checkOutput("midrst_we", 32'(bus.we), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    applyStimulus(32'd50);
    collectJob(32'd50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
